router_decap_ctrl: RTL and testbench
====================================

// Module: router_decap_ctrl
// PURPOSE
//  Receive-side counterpart of the router controller: decapsulates packets that
//  the crossbar delivered to local output port 0. On start_decap_pkt it pops a
//  header flit, decodes dst addr / TTL / source router / length, wins the memory
//  write arbiter, then streams the payload flits into local memory at dst addr.
// PARAMETERS
//  AURORA_DATA_WIDTH       64  flit width (header fields below fixed for 64)
//  ADDR_WIDTH              10  local memory word address width
//  NUMBER_PACKET           19  max flits per packet incl. header (payload <= 18)
//  RECOGNIZE_ROUTER_WIDTH   2  source-router id width
// PORTS
//  clk                   in   1   clock
//  rst                   in   1   synchronous reset, active-high
//  start_decap_pkt       in   1   level; decap permitted while high
//  fifo_empty            in   1   output-port-0 FIFO empty
//  fifo_rd               out  1   FIFO pop; data valid on fifo_rdata next cycle
//  fifo_rdata            in   64  FIFO read data
//  arbiter_write_req     out  1   memory write-port request
//  arbiter_write_gnt     in   1   grant; holds while req held
//  mem_we                out  1   memory write enable
//  mem_addr              out  ADDR_WIDTH  memory write address
//  mem_wdata             out  64  memory write data
//  dst_addr_arbiter_recv out  ADDR_WIDTH  decoded destination address
//  header_pkt_recv       out  9   decoded header bits [8:0]
//  decode_done           out  1   one-cycle pulse: packet fully written
//  decode_err            out  1   one-cycle pulse: packet dropped
// BEHAVIOUR
//  Header flit: [18:9] dst addr, [8:7] TTL, [6:5] src router, [4:0] payload len;
//   [63:19] ignored. Legal len = 1..NUMBER_PACKET-1; else drop packet.
//  Reset: all outputs 0, FSM IDLE, beat counter 0. Reset mid-packet aborts;
//   remaining flits stay in FIFO (no drain).
//  fifo_rd is combinational: high only in RD_HDR/RD_PLD/DROP and !fifo_empty;
//   FSM leaves those states only on a pop. Never pops when empty.
//  FSM:
//   IDLE    -> RD_HDR when start_decap_pkt && !fifo_empty
//   RD_HDR  pop header -> DEC_HDR
//   DEC_HDR latch fifo_rdata; dst_addr_arbiter_recv, header_pkt_recv update;
//           len legal -> ARB_REQ; len 0 or >18 -> DONE_ERR (header only dropped)
//   ARB_REQ arbiter_write_req=1 (registered, stays high through WR_PLD);
//           gnt -> RD_PLD
//   RD_PLD  pop one payload flit (stall while empty, req held) -> WR_PLD
//   WR_PLD  mem_we=1, mem_wdata=fifo_rdata, mem_addr=dst+beat; beat++;
//           beat==len -> DONE else RD_PLD
//   DONE    decode_done=1, req drops -> IDLE
//   DONE_ERR decode_err=1 -> IDLE
//  Address arithmetic mod 2^ADDR_WIDTH: dst 0x3FF, beat 1 writes 0x000.
//  Best-case latency, header to first mem_we: 5 cycles (gnt same cycle as req).
//  start_decap_pkt deassert mid-packet: ignored; packet completes.
//  gnt loss while req held is a protocol violation; behaviour undefined.
//  mem_we, decode_done, decode_err mutually exclusive in any cycle.
// CONFIGURATION
//  DECAP_TTL_CHECK_EN defined: header with TTL==0 is dropped (DROP state pops
//   len payload flits, no mem_we, no arbiter_write_req) then decode_err pulse.
//  Undefined: TTL not inspected; TTL==0 packets written normally.
// TESTING
//  1. Hdr dst=0x040,len=3 + flits A,B,C; gnt immediate -> mem_we at 0x040/41/42
//     with A,B,C; one decode_done; FIFO empty after; 5 cyc hdr-pop to 1st write.
//  2. Same, gnt delayed 10 cyc -> req held 10 cyc, no fifo_rd/mem_we until gnt.
//  3. FIFO empty 4 cyc between flits 1 and 2 -> fifo_rd low during gap, req
//     held, addresses still contiguous, single decode_done.
//  4. len=0 and len=19 headers -> decode_err pulse each, no req, no mem_we,
//     next packet decoded normally.
//  5. dst=0x3FF,len=2 -> writes 0x3FF then 0x000.
//  6. rst asserted in WR_PLD of beat 2 -> next cycle all outputs 0, IDLE;
//     with DECAP_TTL_CHECK_EN, TTL=0 len=2 -> 3 pops, decode_err, no mem_we.

Source files
------------

// File: rtl/router_decap_ctrl.sv
// router_decap_ctrl
// Receive-side decapsulation for packets delivered to local output port 0.
// Pops a header flit, decodes dst/TTL/src/len, wins the memory write arbiter,
// then streams the payload flits into local memory starting at dst.
// Optional feature macro: DECAP_TTL_CHECK_EN. When defined, headers with
// TTL==0 are dropped: their payload is popped and discarded, then decode_err
// pulses.
module router_decap_ctrl #(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_PACKET          = 19,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_decap_pkt_i,
  input  logic                         fifo_empty_i,
  output logic                         fifo_rd_o,
  input  logic [AURORA_DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                         arbiter_write_req_o,
  input  logic                         arbiter_write_gnt_i,
  output logic                         mem_we_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [AURORA_DATA_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0]        dst_addr_arbiter_recv_o,
  output logic [8:0]                   header_pkt_recv_o,
  output logic                         decode_done_o,
  output logic                         decode_err_o
);

  localparam logic [4:0] MAX_LEN = 5'(NUMBER_PACKET - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RD_HDR   = 4'd1,
    ST_DEC_HDR  = 4'd2,
    ST_ARB_REQ  = 4'd3,
    ST_RD_PLD   = 4'd4,
    ST_WR_PLD   = 4'd5,
    ST_DONE     = 4'd6,
    ST_DONE_ERR = 4'd7,
    ST_DROP     = 4'd8
  } state_e;

  state_e                         state_q, state_d;
  logic [4:0]                     beat_q, beat_d;
  logic [4:0]                     len_q, len_d;
  logic [ADDR_WIDTH-1:0]          dst_q, dst_d;
  logic [8:0]                     hdr_q, hdr_d;
  logic                           req_q, req_d;
  logic                           we_q, we_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [AURORA_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
  logic                           hdr_len_ok_s;
  logic                           last_beat_s;

  // Length field is legal only in 1..NUMBER_PACKET-1 (header flit on the bus in DEC_HDR).
  assign hdr_len_ok_s = (fifo_rdata_i[4:0] != 5'd0) && (fifo_rdata_i[4:0] <= MAX_LEN);
  assign last_beat_s  = ((beat_q + 5'd1) == len_q);

  // State register with synchronous reset; reset mid-packet simply abandons it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pop states advance only when a pop actually happens.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_decap_pkt_i && !fifo_empty_i) state_d = ST_RD_HDR;
        else                                    state_d = ST_IDLE;
      end
      ST_RD_HDR: begin
        if (!fifo_empty_i) state_d = ST_DEC_HDR;
        else               state_d = ST_RD_HDR;
      end
      ST_DEC_HDR: begin
        if (!hdr_len_ok_s) begin
          state_d = ST_DONE_ERR;
`ifdef DECAP_TTL_CHECK_EN
        end else if (fifo_rdata_i[8:7] == 2'd0) begin
          state_d = ST_DROP;
`endif
        end else begin
          state_d = ST_ARB_REQ;
        end
      end
      ST_ARB_REQ: begin
        if (arbiter_write_gnt_i) state_d = ST_RD_PLD;
        else                     state_d = ST_ARB_REQ;
      end
      ST_RD_PLD: begin
        if (!fifo_empty_i) state_d = ST_WR_PLD;
        else               state_d = ST_RD_PLD;
      end
      ST_WR_PLD: begin
        if (last_beat_s) state_d = ST_DONE;
        else             state_d = ST_RD_PLD;
      end
      ST_DROP: begin
        if (!fifo_empty_i && last_beat_s) state_d = ST_DONE_ERR;
        else                              state_d = ST_DROP;
      end
      ST_DONE:     state_d = ST_IDLE;
      ST_DONE_ERR: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; fifo_rd is the only combinational output.
  always_comb begin
    fifo_rd_o = 1'b0;
    beat_d    = beat_q;
    len_d     = len_q;
    dst_d     = dst_q;
    hdr_d     = hdr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = (state_q == ST_DONE);
    err_d     = (state_q == ST_DONE_ERR);
    req_d     = (state_d == ST_ARB_REQ) || (state_d == ST_RD_PLD) || (state_d == ST_WR_PLD);
    case (state_q)
      ST_IDLE: begin
        beat_d = 5'd0;
      end
      ST_RD_HDR: begin
        fifo_rd_o = !fifo_empty_i;
      end
      ST_DEC_HDR: begin
        beat_d = 5'd0;
        len_d  = fifo_rdata_i[4:0];
        dst_d  = fifo_rdata_i[9 +: ADDR_WIDTH];
        hdr_d  = {fifo_rdata_i[8:7], fifo_rdata_i[5 +: RECOGNIZE_ROUTER_WIDTH], fifo_rdata_i[4:0]};
      end
      ST_RD_PLD: begin
        fifo_rd_o = !fifo_empty_i;
      end
      ST_WR_PLD: begin
        // Address wraps naturally at 2^ADDR_WIDTH.
        we_d    = 1'b1;
        addr_d  = dst_q + ADDR_WIDTH'(beat_q);
        wdata_d = fifo_rdata_i;
        beat_d  = beat_q + 5'd1;
      end
      ST_DROP: begin
        fifo_rd_o = !fifo_empty_i;
        if (!fifo_empty_i) beat_d = beat_q + 5'd1;
        else               beat_d = beat_q;
      end
      default: begin
        beat_d = beat_q;
      end
    endcase
  end

  // Registered outputs and packet context, all cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q  <= 5'd0;
      len_q   <= 5'd0;
      dst_q   <= '0;
      hdr_q   <= 9'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      len_q   <= len_d;
      dst_q   <= dst_d;
      hdr_q   <= hdr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign arbiter_write_req_o     = req_q;
  assign mem_we_o                = we_q;
  assign mem_addr_o              = addr_q;
  assign mem_wdata_o             = wdata_q;
  assign dst_addr_arbiter_recv_o = dst_q;
  assign header_pkt_recv_o       = hdr_q;
  assign decode_done_o           = done_q;
  assign decode_err_o            = err_q;

endmodule

// File: tb/tb_router_decap_ctrl.sv
// Directed testbench for router_decap_ctrl with a behavioural output-port FIFO.
module tb_router_decap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [63:0] fifo_rdata = 64'd0;
  logic        req;
  logic        gnt = 1'b0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [9:0]  dst_recv;
  logic [8:0]  hdr_recv;
  logic        done;
  logic        err;

  router_decap_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_decap_pkt_i(start), .fifo_empty_i(fifo_empty),
    .fifo_rd_o(fifo_rd), .fifo_rdata_i(fifo_rdata), .arbiter_write_req_o(req),
    .arbiter_write_gnt_i(gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .dst_addr_arbiter_recv_o(dst_recv),
    .header_pkt_recv_o(hdr_recv), .decode_done_o(done), .decode_err_o(err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: data appears on fifo_rdata the cycle after a pop.
  logic [63:0] fq [0:63];
  int          wp = 0;
  int          rp = 0;
  logic        flush_req = 1'b0;
  logic        pop_empty_seen = 1'b0;
  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd && fifo_empty) pop_empty_seen <= 1'b1;
    if (flush_req) begin
      rp <= wp;
    end else if (fifo_rd && !fifo_empty) begin
      fifo_rdata <= fq[rp];
      rp <= rp + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Observation log, filled by observe()
  int          cyc, nw, nrd, ndone, nerr, nrise, excl_bad, gdelay, reqcnt;
  logic        req_prev;
  logic [9:0]  wa [0:31];
  logic [63:0] wd [0:31];
  int          wcyc [0:31];
  int          rd_cyc [0:31];

  function automatic logic [63:0] mk_hdr(input logic [9:0] dst, input logic [1:0] ttl,
                                         input logic [1:0] src, input logic [4:0] len);
    return {45'h0A5A55A5A, dst, ttl, src, len};
  endfunction

  task automatic push(input logic [63:0] d);
    fq[wp] = d;
    wp = wp + 1;
  endtask

  task automatic clear_obs(input int delay);
    cyc = 0; nw = 0; nrd = 0; ndone = 0; nerr = 0; nrise = 0; excl_bad = 0;
    gdelay = delay; reqcnt = 0; req_prev = req;
    for (int k = 0; k < 32; k++) begin
      wa[k] = 'x; wd[k] = 'x; wcyc[k] = -1; rd_cyc[k] = -1;
    end
  endtask

  // Step n cycles, sampling on the falling edge and answering the arbiter.
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_we && nw < 32) begin wa[nw] = mem_addr; wd[nw] = mem_wdata; wcyc[nw] = cyc; nw++; end
      if (fifo_rd && nrd < 32) begin rd_cyc[nrd] = cyc; nrd++; end
      if (done) ndone++;
      if (err) nerr++;
      if (req && !req_prev) nrise++;
      if ((int'(mem_we) + int'(done) + int'(err)) > 1) excl_bad++;
      req_prev = req;
      if (req) reqcnt++; else reqcnt = 0;
      gnt = req && (reqcnt > gdelay);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gnt = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fifo_rd, req, mem_we, done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {fifo_rd, req, mem_we, done, err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, dst_recv, hdr_recv} !== 93'd0) begin
      n_fail++; $display("FAIL reset_data: got addr=%h wdata=%h dst=%h hdr=%h expected all 0",
                         mem_addr, mem_wdata, dst_recv, hdr_recv);
    end
    rst = 1'b0;
    clear_obs(0);
    observe(3);
    n_checks++;
    if (nrd !== 0 || nrise !== 0) begin
      n_fail++; $display("FAIL reset_idle: got pops=%0d reqs=%0d expected 0/0", nrd, nrise);
    end
  endtask

  task automatic test_basic();
    logic [63:0] d [0:2];
    d[0] = 64'hAAAA_0000_0000_0001; d[1] = 64'hBBBB_0000_0000_0002; d[2] = 64'hCCCC_0000_0000_0003;
    clear_obs(0);
    push(mk_hdr(10'h040, 2'd2, 2'd1, 5'd3));
    for (int k = 0; k < 3; k++) push(d[k]);
    start = 1'b1;
    observe(16);
    start = 1'b0;
    n_checks++;
    if (nw !== 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d expected 3", nw); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (wa[k] !== 10'(10'h040 + k) || wd[k] !== d[k]) begin
        n_fail++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", k, wa[k], wd[k], 10'(10'h040 + k), d[k]);
      end
    end
    n_checks++;
    if (wcyc[0] - rd_cyc[0] !== 5) begin
      n_fail++; $display("FAIL basic_latency: got %0d expected 5", wcyc[0] - rd_cyc[0]);
    end
    n_checks++;
    if (ndone !== 1 || nerr !== 0 || nrd !== 4) begin
      n_fail++; $display("FAIL basic_counts: got done=%0d err=%0d pops=%0d expected 1/0/4", ndone, nerr, nrd);
    end
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL basic_fifo_empty: got %b expected 1", fifo_empty); end
    n_checks++;
    if (dst_recv !== 10'h040 || hdr_recv !== 9'b10_01_00011) begin
      n_fail++; $display("FAIL basic_decode: got dst=%h hdr=%b expected 040/100100011", dst_recv, hdr_recv);
    end
    n_checks++;
    if (excl_bad !== 0) begin n_fail++; $display("FAIL basic_exclusive: got %0d overlaps expected 0", excl_bad); end
  endtask

  task automatic test_gnt_delay();
    clear_obs(10);
    push(mk_hdr(10'h0C0, 2'd1, 2'd0, 5'd3));
    push(64'h1); push(64'h2); push(64'h3);
    start = 1'b1;
    observe(28);
    start = 1'b0;
    n_checks++;
    if (rd_cyc[1] - rd_cyc[0] !== 13) begin
      n_fail++; $display("FAIL gnt_first_payload_pop: got %0d expected 13", rd_cyc[1] - rd_cyc[0]);
    end
    n_checks++;
    if (wcyc[0] - rd_cyc[0] !== 15) begin
      n_fail++; $display("FAIL gnt_first_write: got %0d expected 15", wcyc[0] - rd_cyc[0]);
    end
    n_checks++;
    if (nw !== 3 || wa[2] !== 10'h0C2 || wd[2] !== 64'h3 || ndone !== 1 || nrise !== 1) begin
      n_fail++; $display("FAIL gnt_result: got writes=%0d last=%h/%h done=%0d reqs=%0d expected 3 0c2/3 1 1",
                         nw, wa[2], wd[2], ndone, nrise);
    end
  endtask

  task automatic test_fifo_gap();
    clear_obs(0);
    push(mk_hdr(10'h100, 2'd3, 2'd2, 5'd3));
    push(64'h11);
    start = 1'b1;
    observe(9);
    n_checks++;
    if (fifo_rd !== 1'b0 || req !== 1'b1 || nw !== 1) begin
      n_fail++; $display("FAIL gap_stall: got rd=%b req=%b writes=%0d expected 0/1/1", fifo_rd, req, nw);
    end
    push(64'h22); push(64'h33);
    observe(12);
    start = 1'b0;
    n_checks++;
    if (nw !== 3 || wa[0] !== 10'h100 || wa[1] !== 10'h101 || wa[2] !== 10'h102 || wd[1] !== 64'h22) begin
      n_fail++; $display("FAIL gap_writes: got n=%0d %h %h %h d1=%h expected 3 100 101 102 22",
                         nw, wa[0], wa[1], wa[2], wd[1]);
    end
    n_checks++;
    if (ndone !== 1 || nrise !== 1 || pop_empty_seen !== 1'b0) begin
      n_fail++; $display("FAIL gap_done: got done=%0d reqs=%0d pop_empty=%b expected 1/1/0", ndone, nrise, pop_empty_seen);
    end
  endtask

  task automatic test_bad_len();
    clear_obs(0);
    push(mk_hdr(10'h010, 2'd1, 2'd0, 5'd0));
    push(mk_hdr(10'h020, 2'd1, 2'd0, 5'd19));
    push(mk_hdr(10'h030, 2'd1, 2'd0, 5'd1));
    push(64'h5555);
    start = 1'b1;
    observe(22);
    start = 1'b0;
    n_checks++;
    if (nerr !== 2 || nrise !== 1) begin
      n_fail++; $display("FAIL badlen_err: got errs=%0d reqs=%0d expected 2/1", nerr, nrise);
    end
    n_checks++;
    if (nw !== 1 || wa[0] !== 10'h030 || wd[0] !== 64'h5555 || ndone !== 1) begin
      n_fail++; $display("FAIL badlen_next_pkt: got n=%0d %h/%h done=%0d expected 1 030/5555 1", nw, wa[0], wd[0], ndone);
    end
    n_checks++;
    if (excl_bad !== 0 || fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL badlen_misc: got overlaps=%0d empty=%b expected 0/1", excl_bad, fifo_empty);
    end
  endtask

  task automatic test_addr_wrap();
    clear_obs(0);
    push(mk_hdr(10'h3FF, 2'd1, 2'd3, 5'd2));
    push(64'hF0); push(64'hF1);
    start = 1'b1;
    observe(14);
    start = 1'b0;
    n_checks++;
    if (nw !== 2 || wa[0] !== 10'h3FF || wa[1] !== 10'h000 || wd[1] !== 64'hF1) begin
      n_fail++; $display("FAIL wrap_addr: got n=%0d %h %h d=%h expected 2 3ff 000 f1", nw, wa[0], wa[1], wd[1]);
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_obs(0);
    push(mk_hdr(10'h080, 2'd1, 2'd0, 5'd3));
    push(64'hA1); push(64'hA2); push(64'hA3);
    start = 1'b1;
    observe(7);
    rst = 1'b1; start = 1'b0;
    observe(1);
    n_checks++;
    if ({fifo_rd, req, mem_we, done, err} !== 5'b0 || {mem_addr, mem_wdata, dst_recv, hdr_recv} !== 93'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got ctl=%b addr=%h dst=%h hdr=%h expected all 0",
                         {fifo_rd, req, mem_we, done, err}, mem_addr, dst_recv, hdr_recv);
    end
    n_checks++;
    if (nw !== 1 || wp - rp !== 1) begin
      n_fail++; $display("FAIL midrst_abort: got writes=%0d left=%0d expected 1/1", nw, wp - rp);
    end
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    rst = 1'b0;
    clear_obs(0);
    observe(3);
    n_checks++;
    if (nrd !== 0 || nrise !== 0 || nw !== 0) begin
      n_fail++; $display("FAIL midrst_idle: got pops=%0d reqs=%0d writes=%0d expected 0", nrd, nrise, nw);
    end
  endtask

  task automatic test_ttl_zero();
    clear_obs(0);
    push(mk_hdr(10'h200, 2'd0, 2'd1, 5'd2));
    push(64'hE0); push(64'hE1);
    start = 1'b1;
    observe(14);
    start = 1'b0;
    n_checks++;
    if (nrd !== 3 || fifo_empty !== 1'b1) begin
      n_fail++; $display("FAIL ttl_pops: got %0d empty=%b expected 3/1", nrd, fifo_empty);
    end
`ifdef DECAP_TTL_CHECK_EN
    n_checks++;
    if (nerr !== 1 || ndone !== 0 || nw !== 0 || nrise !== 0) begin
      n_fail++; $display("FAIL ttl_drop: got err=%0d done=%0d writes=%0d reqs=%0d expected 1/0/0/0", nerr, ndone, nw, nrise);
    end
`else
    n_checks++;
    if (nerr !== 0 || ndone !== 1 || nw !== 2 || wa[0] !== 10'h200 || wa[1] !== 10'h201 || wd[0] !== 64'hE0) begin
      n_fail++; $display("FAIL ttl_pass: got err=%0d done=%0d writes=%0d %h %h expected 0/1/2 200 201",
                         nerr, ndone, nw, wa[0], wa[1]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_delay();
    test_fifo_gap();
    test_bad_len();
    test_addr_wrap();
    test_reset_mid_packet();
    test_ttl_zero();
    n_checks++;
    if (pop_empty_seen !== 1'b0) begin
      n_fail++; $display("FAIL pop_when_empty: got %b expected 0", pop_empty_seen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
